// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  mem_arbiter_pkg
//  Shared types and constants for the main-memory arbiter: FSM state
//  encoding, fill-target select values and default geometry.
//  Revision: 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        FILL  = 2'b10
    } arb_state_t;

    localparam logic c_SEL_I = 1'b0;
    localparam logic c_SEL_D = 1'b1;

    localparam int c_MEM_LAT_DEF   = 4;
    localparam int c_BLK_WORDS_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/mem_arb_fill_ctr.sv
`default_nettype none
// ============================================================================
//  mem_arb_fill_ctr
//  Issue/receive counter pair for one block fill. Generates the read issue
//  address, the beat write-back address and flags the final beat.
//  Ports:
//    clk, rst        clock, asynchronous active-high reset
//    active          high while the arbiter is in FILL; counters clear otherwise
//    mem_valid       returning read beat
//    base            latched block base address
//    issue           a read should be issued this cycle
//    issue_addr      base + 2*ic
//    beat            a beat is being accepted this cycle
//    beat_addr       base + 2*rc
//    last_beat       accepted beat is the final word of the block
//  Revision: 1.0  initial release
// ============================================================================
module mem_arb_fill_ctr #(
    parameter int BLK_WORDS = 8,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          active,
    input  logic          mem_valid,
    input  logic [AW-1:0] base,
    output logic          issue,
    output logic [AW-1:0] issue_addr,
    output logic          beat,
    output logic [AW-1:0] beat_addr,
    output logic          last_beat
);

    localparam int                c_CW  = $clog2(BLK_WORDS) + 1;
    localparam logic [c_CW-1:0]   c_BLK = c_CW'(BLK_WORDS);

    logic [c_CW-1:0] r_ic;
    logic [c_CW-1:0] r_rc;

    assign issue      = active && (r_ic < c_BLK);
    assign beat       = active && mem_valid;
    assign last_beat  = beat && (r_rc == c_BLK - c_CW'(1));
    // Base is block aligned, so adding the word offset never carries into tag bits.
    assign issue_addr = base + AW'({r_ic, 1'b0});
    assign beat_addr  = base + AW'({r_rc, 1'b0});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ic <= '0;
            r_rc <= '0;
        end else if (!active || last_beat) begin
            r_ic <= '0;
            r_rc <= '0;
        end else begin
            if (issue) r_ic <= r_ic + c_CW'(1);
            if (beat)  r_rc <= r_rc + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  mem_arbiter
//  Single owner of the pipelined main memory. Arbitrates D-side stores,
//  D-cache fills and I-cache fills (fixed priority d_wr > d_miss > i_miss),
//  sequences each block fill and steers returning words to the missing cache.
//  Optional macro MEM_ARB_RR_EN: alternate D/I grants on simultaneous misses.
//  Ports:
//    clk, rst                       clock, asynchronous active-high reset
//    i_miss/i_addr, d_miss/d_addr   cache fill requests (level)
//    d_wr/d_wr_addr/d_wr_data       store request, held until d_wr_ack
//    mem_en/mem_wr/mem_addr/mem_wdata, mem_valid/mem_rdata   memory side
//    fill_we/fill_tag_we/fill_sel/fill_addr/fill_data        cache fill side
//    i_done, d_done, d_wr_ack       completion pulses
//    busy                           not in IDLE
//  Revision: 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT   = c_MEM_LAT_DEF,
    parameter int BLK_WORDS = c_BLK_WORDS_DEF,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_miss,
    input  logic [AW-1:0] i_addr,
    input  logic          d_miss,
    input  logic [AW-1:0] d_addr,
    input  logic          d_wr,
    input  logic [AW-1:0] d_wr_addr,
    input  logic [15:0]   d_wr_data,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic          mem_valid,
    input  logic [15:0]   mem_rdata,
    output logic          fill_we,
    output logic          fill_tag_we,
    output logic          fill_sel,
    output logic [AW-1:0] fill_addr,
    output logic [15:0]   fill_data,
    output logic          i_done,
    output logic          d_done,
    output logic          d_wr_ack,
    output logic          busy
);

    localparam logic [AW-1:0] c_BLK_MASK = ~AW'(2 * BLK_WORDS - 1);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [AW-1:0] r_base;
    logic          r_sel;
    logic          w_grant;
    logic          w_grant_sel;
    logic          w_issue;
    logic          w_beat;
    logic          w_last;
    logic [AW-1:0] w_issue_addr;
    logic [AW-1:0] w_beat_addr;

    assign w_grant = (r_state == IDLE) && !d_wr && (d_miss || i_miss);

`ifdef MEM_ARB_RR_EN
    // Remembers the target of the previous fill; starts at D so I wins the first tie.
    logic r_last_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_last_sel <= c_SEL_D;
        else if (w_grant) r_last_sel <= w_grant_sel;
    end

    assign w_grant_sel = (d_miss && i_miss) ? ~r_last_sel : d_miss;
`else
    assign w_grant_sel = d_miss ? c_SEL_D : c_SEL_I;
`endif

    mem_arb_fill_ctr #(
        .BLK_WORDS (BLK_WORDS),
        .AW        (AW)
    ) u_fill_ctr (
        .clk        (clk),
        .rst        (rst),
        .active     (r_state == FILL),
        .mem_valid  (mem_valid),
        .base       (r_base),
        .issue      (w_issue),
        .issue_addr (w_issue_addr),
        .beat       (w_beat),
        .beat_addr  (w_beat_addr),
        .last_beat  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_sel   <= c_SEL_I;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_base <= ((w_grant_sel == c_SEL_D) ? d_addr : i_addr) & c_BLK_MASK;
                r_sel  <= w_grant_sel;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_we     = 1'b0;
        fill_tag_we = 1'b0;
        fill_sel    = 1'b0;
        fill_addr   = '0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        d_wr_ack    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_wr)                  w_state_nxt = WRITE;
                else if (d_miss || i_miss) w_state_nxt = FILL;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_wdata   = d_wr_data;
                d_wr_ack    = 1'b1;
                w_state_nxt = IDLE;
            end
            FILL: begin
                busy        = 1'b1;
                fill_sel    = r_sel;
                fill_addr   = w_beat_addr;
                fill_we     = w_beat;
                fill_tag_we = w_last;
                if (w_issue) begin
                    mem_en   = 1'b1;
                    mem_addr = w_issue_addr;
                end
                if (w_last) begin
                    i_done      = (r_sel == c_SEL_I);
                    d_done      = (r_sel == c_SEL_D);
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign fill_data = mem_rdata;

    // The final beat of a fill always answers the last read issued MEM_LAT cycles earlier.
    a_last_beat_latency: assert property (@(posedge clk) disable iff (rst)
        fill_tag_we |-> $past(mem_en, MEM_LAT));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_mem_arbiter
//  Self-checking bench for mem_arbiter: grant table, directed fill/store
//  sequences, reset during a fill, then randomized traffic against a
//  transaction-timing reference model and a 4-cycle pipelined memory.
//  Revision: 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int BLK = 8;
    localparam int LAT = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 0, d_miss = 0, d_wr = 0, mem_valid = 0;
    logic [15:0] i_addr = 0, d_addr = 0, d_wr_addr = 0, d_wr_data = 0, mem_rdata = 0;
    logic        mem_en, mem_wr, fill_we, fill_tag_we, fill_sel, i_done, d_done, d_wr_ack, busy;
    logic [15:0] mem_addr, mem_wdata, fill_addr, fill_data;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT), .BLK_WORDS(BLK), .AW(16)) dut (
        .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_tag_we(fill_tag_we), .fill_sel(fill_sel), .fill_addr(fill_addr),
        .fill_data(fill_data), .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic [15:0] mem [0:32767];
    logic        ring_v [0:7];
    logic [15:0] ring_d [0:7];

    // reference model: transaction kind, cycles elapsed since grant, latched block
    int          m_mode = 0;   // 0 idle, 1 store, 2 fill
    int          m_k = 0;
    logic [15:0] m_base = 0;
    logic        m_sel = 0, m_last = 1;
    logic        ev_i_done = 0, ev_d_done = 0, ev_ack = 0;
    logic        s_i_done, s_d_done, s_ack, s_fill_we;
    int          s_cyc;
    int          c_idone, c_ddone, c_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // falling edge: memory captures this cycle's command
    task automatic to_neg();
        @(negedge clk);
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin
            ring_v[(cyc + LAT) % 8] = 1'b1;
            ring_d[(cyc + LAT) % 8] = mem[mem_addr[15:1]];
        end
        if (mem_en === 1'b1 && mem_wr === 1'b1) mem[mem_addr[15:1]] = mem_wdata;
    endtask

    // just after the rising edge: memory presents the beat due this cycle
    task automatic to_pos();
        @(posedge clk);
        #1;
        cyc++;
        mem_valid = ring_v[cyc % 8];
        mem_rdata = ring_v[cyc % 8] ? ring_d[cyc % 8] : 16'h0;
        ring_v[cyc % 8] = 1'b0;
    endtask

    task automatic model_cycle();
        logic [7:0]  ec, ac;
        logic [15:0] e_maddr, e_faddr, a;
        logic        e_fsel;
        to_neg();
        s_i_done = i_done; s_d_done = d_done; s_ack = d_wr_ack; s_fill_we = fill_we; s_cyc = cyc;
        if (rst) begin m_mode = 0; m_k = 0; m_last = 1'b1; end
        ec = 8'h0; e_maddr = 16'h0; e_faddr = 16'h0; e_fsel = 1'b0;
        ev_i_done = 0; ev_d_done = 0; ev_ack = 0;
        if (m_mode == 1) begin
            ec = 8'b1100_0011; e_maddr = d_wr_addr; ev_ack = 1;
        end else if (m_mode == 2) begin
            ec[0] = 1'b1;
            if (m_k <= BLK) begin ec[7] = 1'b1; e_maddr = m_base + 16'(2 * (m_k - 1)); end
            if (m_k > LAT) begin ec[5] = 1'b1; e_faddr = m_base + 16'(2 * (m_k - 1 - LAT)); e_fsel = m_sel; end
            if (m_k == BLK + LAT) begin
                ec[4] = 1'b1;
                if (m_sel) begin ec[2] = 1'b1; ev_d_done = 1; end
                else       begin ec[3] = 1'b1; ev_i_done = 1; end
            end
        end
        ac = {mem_en, mem_wr, fill_we, fill_tag_we, i_done, d_done, d_wr_ack, busy};
        chk("ctrl{en,wr,we,tag,idone,ddone,ack,busy}", ac, ec);
        if (ec[7]) chk("mem_addr", mem_addr, e_maddr);
        if (ec[6]) chk("mem_wdata", mem_wdata, d_wr_data);
        if (ec[5]) begin
            chk("fill_addr", fill_addr, e_faddr);
            chk("fill_sel", fill_sel, e_fsel);
            chk("fill_data", fill_data, mem[e_faddr[15:1]]);
        end
        if (rst) chk("reset zeros{mem_addr,fill_addr,wdata,sel}",
                     {mem_addr, fill_addr}, {mem_wdata[15:1], fill_sel, 16'h0} & 32'h0);
        if (rst) chk("reset wdata/sel", {15'h0, fill_sel, mem_wdata}, 32'h0);
        if (!rst) begin
            case (m_mode)
                0: begin
                    if (d_wr) m_mode = 1;
                    else if (d_miss || i_miss) begin
                        if (d_miss && i_miss) m_sel = RR ? ~m_last : 1'b1;
                        else                  m_sel = d_miss;
                        a = m_sel ? d_addr : i_addr;
                        m_base = a - (a % 16'(2 * BLK));
                        m_last = m_sel; m_mode = 2; m_k = 1;
                    end
                end
                1: m_mode = 0;
                default: if (m_k == BLK + LAT) m_mode = 0; else m_k++;
            endcase
        end
        to_pos();
    endtask

    // run with requesters releasing on completion; record first actual completion cycles
    task automatic run_seq(input int n);
        c_idone = -1; c_ddone = -1; c_ack = -1;
        for (int j = 0; j < n; j++) begin
            model_cycle();
            if (s_i_done && c_idone < 0) c_idone = s_cyc;
            if (s_d_done && c_ddone < 0) c_ddone = s_cyc;
            if (s_ack && c_ack < 0) c_ack = s_cyc;
            if (ev_i_done) i_miss = 0;
            if (ev_d_done) d_miss = 0;
            if (ev_ack) d_wr = 0;
            if (!i_miss && !d_miss && !d_wr && m_mode == 0) break;
        end
    endtask

    task automatic reset_dut();
        i_miss = 0; d_miss = 0; d_wr = 0; rst = 1;
        model_cycle(); model_cycle();
        rst = 0;
    endtask

    typedef struct {
        logic dwr, dmiss, imiss;
        logic [15:0] iaddr, daddr, waddr, wdata;
        logic e_busy, e_en, e_wr, e_ack;
        logic [15:0] e_addr;
    } vec_t;

    vec_t tbl [8];
    int   t0, cnt;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 2);
        for (int i = 0; i < 8; i++) begin ring_v[i] = 0; ring_d[i] = 0; end

        //             wr miss: d i   i_addr    d_addr    wr_addr   wr_data   busy en wr ack  mem_addr
        tbl[0] = '{0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000};
        tbl[1] = '{0, 0, 1, 16'h0134, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0130};
        tbl[2] = '{0, 1, 0, 16'h0000, 16'h2006, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h2000};
        tbl[3] = '{1, 1, 0, 16'h0000, 16'h0300, 16'h0042, 16'hBEEF, 1, 1, 1, 1, 16'h0042};
        tbl[4] = '{0, 1, 1, 16'h0010, 16'h2000, 16'h0000, 16'h0000, 1, 1, 0, 0, RR ? 16'h0010 : 16'h2000};
        tbl[5] = '{1, 1, 1, 16'h0500, 16'h0600, 16'h1234, 16'h5A5A, 1, 1, 1, 1, 16'h1234};
        tbl[6] = '{0, 0, 1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'hFFF0};
        tbl[7] = '{0, 1, 0, 16'h0000, 16'h000F, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000};

        to_pos();
        model_cycle();                       // reset state, all outputs zero
        rst = 0;

        // first cycle after a grant decision from IDLE
        for (int i = 0; i < 8; i++) begin
            rst = 1; to_neg(); to_pos(); rst = 0;
            d_wr = tbl[i].dwr; d_miss = tbl[i].dmiss; i_miss = tbl[i].imiss;
            i_addr = tbl[i].iaddr; d_addr = tbl[i].daddr; d_wr_addr = tbl[i].waddr; d_wr_data = tbl[i].wdata;
            to_neg(); to_pos();
            to_neg();
            chk($sformatf("tbl[%0d] {busy,en,wr,ack}", i), {busy, mem_en, mem_wr, d_wr_ack},
                {tbl[i].e_busy, tbl[i].e_en, tbl[i].e_wr, tbl[i].e_ack});
            if (tbl[i].e_en) chk($sformatf("tbl[%0d] mem_addr", i), mem_addr, tbl[i].e_addr);
            if (tbl[i].e_wr) chk($sformatf("tbl[%0d] mem_wdata", i), mem_wdata, tbl[i].wdata);
            to_pos();
            d_wr = 0; d_miss = 0; i_miss = 0;
        end

        rst = 1;
        for (int i = 0; i < 10; i++) model_cycle();
        rst = 0;

        // I fill of block 0x0130
        t0 = cyc; i_miss = 1; i_addr = 16'h0134;
        run_seq(40);
        chk("I fill latency", c_idone - t0, 12);

        // simultaneous misses
        reset_dut();
        i_miss = 1; i_addr = 16'h0010; d_miss = 1; d_addr = 16'h2000;
        run_seq(60);
        chk("tie both completed", {31'h0, c_idone >= 0 && c_ddone >= 0}, 1);
        chk("tie D served first", {31'h0, c_ddone < c_idone}, {31'h0, !RR});
        chk("tie back-to-back gap", (c_idone > c_ddone) ? c_idone - c_ddone : c_ddone - c_idone, 13);

        // store together with a D miss
        t0 = cyc; d_wr = 1; d_wr_addr = 16'h0042; d_wr_data = 16'hBEEF; d_miss = 1; d_addr = 16'h0300;
        run_seq(40);
        chk("store ack cycle", c_ack - t0, 1);
        chk("fill after store", c_ddone - c_ack, 13);

        // store raised during an I fill
        t0 = cyc; i_miss = 1; i_addr = 16'h0550;
        for (int j = 0; j < 4; j++) model_cycle();
        d_wr = 1; d_wr_addr = 16'h0770; d_wr_data = 16'h1357;
        run_seq(40);
        chk("I fill latency w/ store wait", c_idone - t0, 12);
        chk("store ack after i_done", c_ack - c_idone, 2);

        // reset after third beat of a D fill
        reset_dut();
        d_miss = 1; d_addr = 16'h4444;
        for (int j = 0; j < 8; j++) model_cycle();
        d_miss = 0; rst = 1;
        model_cycle(); model_cycle();
        rst = 0;
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            model_cycle();
            cnt += int'(s_fill_we) + int'(s_d_done);
        end
        chk("stray beats/done after reset", cnt, 0);
        t0 = cyc; i_miss = 1; i_addr = 16'h0A08;
        run_seq(40);
        chk("I fill after reset latency", c_idone - t0, 12);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (ev_ack) d_wr = 0;
            else if (!d_wr && $urandom_range(3) == 0) begin
                d_wr = 1; d_wr_addr = 16'($urandom) & 16'hFFFE; d_wr_data = 16'($urandom);
            end
            if (ev_i_done) i_miss = 0;
            else if (i_miss && m_mode == 2 && !m_sel && $urandom_range(7) == 0) i_miss = 0;
            else if (!i_miss && !(m_mode == 2 && !m_sel) && $urandom_range(4) == 0) i_miss = 1;
            if (ev_d_done) d_miss = 0;
            else if (d_miss && m_mode == 2 && m_sel && $urandom_range(7) == 0) d_miss = 0;
            else if (!d_miss && !(m_mode == 2 && m_sel) && $urandom_range(4) == 0) d_miss = 1;
            i_addr = 16'($urandom);
            d_addr = 16'($urandom);
            model_cycle();
        end
        d_wr = 0; i_miss = 0; d_miss = 0;
        for (int j = 0; j < 20; j++) model_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
